ft_tx_arbiter: RTL and testbench

//  Packet-level round-robin arbiter sharing the FT USB transmit path (ft ui_din/ui_din_full)

---
 rtl/ft_tx_arbiter_if.sv | 38 +++
 rtl/ft_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ft_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft_tx_arbiter_if.sv
// ============================================================================
// Module      : ft_tx_arbiter_if
// Description : Requester and FT transmit bus bundle for ft_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ft_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [16*NUM_REQ-1:0] req_data;
  logic [2*NUM_REQ-1:0]  req_be;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ-1:0]    req_ready;
  logic [15:0]           ui_din;
  logic [1:0]            ui_din_be;
  logic                  ui_din_valid;
  logic                  ui_din_full;
  logic [NUM_REQ-1:0]    grant;
  logic                  busy;
  logic [15:0]           pkt_count;
  logic [15:0]           trunc_count;

  modport slave (
    input  req_data, req_be, req_valid, req_last, ui_din_full,
    output req_ready, ui_din, ui_din_be, ui_din_valid, grant, busy,
           pkt_count, trunc_count
  );

  modport master (
    output req_data, req_be, req_valid, req_last, ui_din_full,
    input  req_ready, ui_din, ui_din_be, ui_din_valid, grant, busy,
           pkt_count, trunc_count
  );
endinterface

`default_nettype wire

// File: rtl/ft_tx_arbiter.sv
// ============================================================================
// Module      : ft_tx_arbiter
// Description : Packet-level round-robin arbiter onto the FT ui_din path.
//               Optional header word per packet with FT_TX_ARB_HEADER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ft_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int MAX_LEN = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  ft_tx_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  state_t               r_state;
  logic [2:0]           r_ptr;
  logic [NUM_REQ-1:0]   r_grant;
  logic [15:0]          r_word_cnt;
  logic [15:0]          r_pkt_count;
  logic [15:0]          r_trunc_count;
`ifdef FT_TX_ARB_HEADER_EN
  logic [2:0]           r_idx;
`endif

  logic                 w_found;
  logic [NUM_REQ-1:0]   w_sel_oh;
  logic [2:0]           w_sel_idx;
  int                   w_best;
  int                   w_dist;
  logic [15:0]          w_din;
  logic [1:0]           w_be;
  logic                 w_valid;
  logic                 w_last;
  logic                 w_xfer;
  logic                 w_at_max;

  // Rotation distance from ptr+1: the smallest distance with valid wins.
  always_comb begin
    w_found   = 1'b0;
    w_sel_oh  = '0;
    w_sel_idx = '0;
    w_best    = NUM_REQ;
    w_dist    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - 1 - int'(r_ptr)) % NUM_REQ;
      if (bus.req_valid[i] && (w_dist < w_best)) begin
        w_best      = w_dist;
        w_found     = 1'b1;
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
        w_sel_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    w_din   = '0;
    w_be    = '0;
    w_valid = 1'b0;
    w_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_din   = bus.req_data[16*i +: 16];
        w_be    = bus.req_be[2*i +: 2];
        w_valid = bus.req_valid[i];
        w_last  = bus.req_last[i];
      end
    end
  end

  assign w_xfer   = (r_state == ST_XFER) && w_valid && !bus.ui_din_full;
  assign w_at_max = (r_word_cnt == 16'(MAX_LEN - 1));

  // Payload path is a zero-latency pass-through of the granted requester.
  always_comb begin
    bus.ui_din       = '0;
    bus.ui_din_be    = '0;
    bus.ui_din_valid = 1'b0;
    bus.req_ready    = '0;
    case (r_state)
      ST_XFER: begin
        bus.ui_din       = w_din;
        bus.ui_din_be    = w_be;
        bus.ui_din_valid = w_valid;
        bus.req_ready    = r_grant & {NUM_REQ{!bus.ui_din_full}};
      end
`ifdef FT_TX_ARB_HEADER_EN
      ST_HDR: begin
        bus.ui_din       = {8'hA5, 5'h00, r_idx};
        bus.ui_din_be    = 2'b11;
        bus.ui_din_valid = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.grant       = r_grant;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.pkt_count   = r_pkt_count;
  assign bus.trunc_count = r_trunc_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= 3'(NUM_REQ - 1);
      r_grant       <= '0;
      r_word_cnt    <= '0;
      r_pkt_count   <= '0;
      r_trunc_count <= '0;
`ifdef FT_TX_ARB_HEADER_EN
      r_idx         <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_sel_oh;
            r_ptr   <= w_sel_idx;
`ifdef FT_TX_ARB_HEADER_EN
            r_idx   <= w_sel_idx;
            r_state <= ST_HDR;
`else
            r_state <= ST_XFER;
`endif
          end
        end
        ST_HDR: begin
          if (!bus.ui_din_full) begin
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_xfer) begin
            // A word that is both last and the MAX_LEN-th is a normal close.
            if (w_last || w_at_max) begin
              r_pkt_count <= r_pkt_count + 16'd1;
              if (!w_last) begin
                r_trunc_count <= r_trunc_count + 16'd1;
              end
              r_word_cnt <= '0;
              r_grant    <= '0;
              r_state    <= ST_IDLE;
            end else begin
              r_word_cnt <= r_word_cnt + 16'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ft_tx_arbiter.sv
// ============================================================================
// Module      : tb_ft_tx_arbiter
// Description : Scoreboard bench for ft_tx_arbiter (NUM_REQ=2, MAX_LEN=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ft_tx_arbiter;
  localparam int NUM_REQ = 2;
  localparam int MAX_LEN = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ft_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  ft_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  be;
    logic        last;
  } src_t;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  be;
    logic [1:0]  gnt;
    logic        hdr;
  } exp_t;

  src_t q0[$];
  src_t q1[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   xfers = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic load_src(int r, logic [15:0] base, int n);
    for (int k = 0; k < n; k++) begin
      src_t s;
      s.data = base + 16'(k);
      s.be   = (k == n - 1) ? 2'b01 : 2'b11;
      s.last = (k == n - 1);
      if (r == 0) q0.push_back(s);
      else        q1.push_back(s);
    end
  endtask

  // Expected words for one granted packet: words first..first+n-1 of a
  // source packet that is total_len words long.
  task automatic exp_run(int r, logic [15:0] base, int first, int n, int total_len);
    exp_t e;
`ifdef FT_TX_ARB_HEADER_EN
    e.data = {8'hA5, 5'h00, 3'(r)};
    e.be   = 2'b11;
    e.gnt  = 2'(1 << r);
    e.hdr  = 1'b1;
    exp_q.push_back(e);
`endif
    for (int k = first; k < first + n; k++) begin
      e.data = base + 16'(k);
      e.be   = (k == total_len - 1) ? 2'b01 : 2'b11;
      e.gnt  = 2'(1 << r);
      e.hdr  = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d words pending expected 0", name, exp_q.size());
      exp_q.delete();
      q0.delete();
      q1.delete();
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic check_idle(string name, logic [15:0] pkt, logic [15:0] trunc);
    check({name, "_busy"},  32'(bus.busy),        32'd0);
    check({name, "_grant"}, 32'(bus.grant),       32'd0);
    check({name, "_pkt"},   32'(bus.pkt_count),   32'(pkt));
    check({name, "_trunc"}, 32'(bus.trunc_count), 32'(trunc));
  endtask

  // Requester models: present the head word, pop it once accepted.
  initial begin
    logic [NUM_REQ-1:0] acc;
    bus.req_data  = '0;
    bus.req_be    = '0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk); #1;
      if (acc[0] && q0.size() > 0) void'(q0.pop_front());
      if (acc[1] && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0) begin
        bus.req_data[15:0] = q0[0].data;
        bus.req_be[1:0]    = q0[0].be;
        bus.req_last[0]    = q0[0].last;
        bus.req_valid[0]   = 1'b1;
      end else begin
        bus.req_data[15:0] = '0;
        bus.req_be[1:0]    = '0;
        bus.req_last[0]    = 1'b0;
        bus.req_valid[0]   = 1'b0;
      end
      if (q1.size() > 0) begin
        bus.req_data[31:16] = q1[0].data;
        bus.req_be[3:2]     = q1[0].be;
        bus.req_last[1]     = q1[0].last;
        bus.req_valid[1]    = 1'b1;
      end else begin
        bus.req_data[31:16] = '0;
        bus.req_be[3:2]     = '0;
        bus.req_last[1]     = 1'b0;
        bus.req_valid[1]    = 1'b0;
      end
    end
  end

  // Monitor: every transfer on ui_din is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.ui_din_valid && !bus.ui_din_full) begin
        xfers++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %h expected none", bus.ui_din);
        end else begin
          e = exp_q.pop_front();
          check("ui_din",    32'(bus.ui_din),    32'(e.data));
          check("ui_din_be", 32'(bus.ui_din_be), 32'(e.be));
          check("grant",     32'(bus.grant),     32'(e.gnt));
          check("req_ready", 32'(bus.req_ready), e.hdr ? 32'd0 : 32'(e.gnt));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int x0;
    bus.ui_din_full = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("rst_valid", 32'(bus.ui_din_valid), 32'd0);
    check_idle("rst", 16'd0, 16'd0);

    // Async reset in the middle of a packet
    load_src(0, 16'h1100, 3);
    exp_run(0, 16'h1100, 0, 3, 3);
    n = 0;
    while (exp_q.size() != 1 && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    check("mid_valid", 32'(bus.ui_din_valid), 32'd1);
    check("mid_grant", 32'(bus.grant),        32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.ui_din_valid), 32'd0);
    check("arst_din",   32'(bus.ui_din),       32'd0);
    check("arst_ready", 32'(bus.req_ready),    32'd0);
    check_idle("arst", 16'd0, 16'd0);
    q0.delete();
    q1.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Round-robin alternation with both requesters busy
    load_src(0, 16'h1000, 3);
    load_src(0, 16'h1000, 3);
    load_src(1, 16'h2000, 3);
    load_src(1, 16'h2000, 3);
    exp_run(0, 16'h1000, 0, 3, 3);
    exp_run(1, 16'h2000, 0, 3, 3);
    exp_run(0, 16'h1000, 0, 3, 3);
    exp_run(1, 16'h2000, 0, 3, 3);
    wait_drain("rr");
    check_idle("rr", 16'd4, 16'd0);

    // Back-pressure for 5 cycles mid-packet
    x0 = xfers;
    load_src(0, 16'h1300, 3);
    exp_run(0, 16'h1300, 0, 3, 3);
    n = 0;
    while (q0.size() != 2 && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    bus.ui_din_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_ready", 32'(bus.req_ready),    32'd0);
      check("stall_din",   32'(bus.ui_din),       32'h1301);
      check("stall_valid", 32'(bus.ui_din_valid), 32'd1);
    end
    @(posedge clk); #2;
    bus.ui_din_full = 1'b0;
    wait_drain("stall");
`ifdef FT_TX_ARB_HEADER_EN
    check("stall_xfers", 32'(xfers - x0), 32'd4);
`else
    check("stall_xfers", 32'(xfers - x0), 32'd3);
`endif
    check_idle("stall", 16'd5, 16'd0);

    // MAX_LEN force-close with requester 1 interleaving
    load_src(0, 16'h3000, 10);
    load_src(1, 16'h4000, 2);
    load_src(1, 16'h4100, 2);
    exp_run(1, 16'h4000, 0, 2, 2);
    exp_run(0, 16'h3000, 0, 4, 10);
    exp_run(1, 16'h4100, 0, 2, 2);
    exp_run(0, 16'h3000, 4, 4, 10);
    exp_run(0, 16'h3000, 8, 2, 10);
    wait_drain("trunc");
    check_idle("trunc", 16'd10, 16'd2);

    // Single packet from requester 1 (header word first when enabled)
    load_src(1, 16'h5000, 2);
    exp_run(1, 16'h5000, 0, 2, 2);
    wait_drain("hdr");
    check_idle("hdr", 16'd11, 16'd2);

    // Packet counter wrap
    force dut.r_pkt_count = 16'hFFFF;
    #1;
    release dut.r_pkt_count;
    #1;
    check("preload_pkt", 32'(bus.pkt_count), 32'h0000FFFF);
    load_src(0, 16'h6000, 1);
    exp_run(0, 16'h6000, 0, 1, 1);
    wait_drain("wrap");
    check_idle("wrap", 16'h0000, 16'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
